// File: rtl/pattern_scan_ctrl.sv
// Programmable serial pattern-scan controller: matches a latched pattern
// against the valid-qualified d_in stream, counts matches, and ends the run at a target count.
//
// state | meaning
// IDLE  | waiting for start; rejects illegal configurations with cfg_err
// SCAN  | shifting valid bits and detecting matches (busy=1)
// DONE  | single cycle after the target was reached
module pattern_scan_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               d_in,
  input  logic               valid_in,
  output logic               busy,
  output logic               pattern_detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_d;
  logic [MAX_LEN-1:0] pat_q, hist, hist_shift, len_mask;
  logic [MAX_LEN:0]   len_onehot;
  logic [LEN_W-1:0]   len_q, fill, fill_inc;
  logic               ovl_q;
  logic [CNT_W-1:0]   tgt_q;
  logic               cfg_bad, accept, shift_en, hit, last_hit;
  logic               busy_d, det_d, done_d, err_d;

  assign cfg_bad    = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN)) || (cfg_target == '0);
  assign accept     = (state == IDLE) && start && !cfg_bad;
  assign shift_en   = (state == SCAN) && valid_in && !abort;
  assign hist_shift = {hist[MAX_LEN-2:0], d_in};
  assign fill_inc   = (fill < len_q) ? fill + LEN_W'(1) : len_q;
  // Width MAX_LEN+1 so that len=MAX_LEN yields an all-ones mask.
  assign len_onehot = (MAX_LEN+1)'(1) << len_q;
  assign len_mask   = MAX_LEN'(len_onehot - (MAX_LEN+1)'(1));
  assign hit        = shift_en && (fill_inc == len_q) && (((hist_shift ^ pat_q) & len_mask) == '0);
  assign last_hit   = hit && ((match_count + CNT_W'(1)) == tgt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      busy             <= 1'b0;
      pattern_detected <= 1'b0;
      done             <= 1'b0;
      cfg_err          <= 1'b0;
    end else begin
      state            <= state_d;
      busy             <= busy_d;
      pattern_detected <= det_d;
      done             <= done_d;
      cfg_err          <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = SCAN;
      SCAN: begin
        if (abort)         state_d = IDLE;
        else if (last_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == SCAN);
    det_d  = hit;
    done_d = last_hit;
    err_d  = (state == IDLE) && start && cfg_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
    end else if (accept) begin
      pat_q       <= cfg_pattern;
      len_q       <= cfg_len;
      ovl_q       <= cfg_overlap;
      tgt_q       <= cfg_target;
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
    end else if (shift_en) begin
      hist <= hist_shift;
      // Non-overlapping mode discards the matched bits by restarting the fill.
      fill <= (hit && !ovl_q) ? '0 : fill_inc;
      if (hit) match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: overlap modes, gaps, target, config errors,
// abort priority, start gating, reset mid-run, and length boundaries.
module tb_pattern_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, cfg_overlap, d_in, valid_in;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic [15:0] cfg_target;
  logic        busy, pattern_detected, done, cfg_err;
  logic [15:0] match_count;
  int          n_checks = 0;
  int          n_pass   = 0;

  pattern_scan_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target), .d_in(d_in), .valid_in(valid_in),
    .busy(busy), .pattern_detected(pattern_detected), .match_count(match_count),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] pat, input logic [3:0] len,
                          input logic ovl, input logic [15:0] tgt);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input string tag, input logic b, input logic exp_det, input logic [15:0] exp_cnt);
    d_in = b; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; d_in = 1'b0;
    check({tag, " det"}, pattern_detected, exp_det);
    check({tag, " cnt"}, match_count, exp_cnt);
  endtask

  task automatic check_outs(input string tag, input logic b, input logic det, input logic dn,
                            input logic err, input logic [15:0] cnt);
    check({tag, " busy"}, busy, b);
    check({tag, " det"}, pattern_detected, det);
    check({tag, " done"}, done, dn);
    check({tag, " cfg_err"}, cfg_err, err);
    check({tag, " cnt"}, match_count, cnt);
  endtask

  // Scenario-1 stream 1,0,1,1,0,1,1 with overlap: matches after bits 4 and 7.
  task automatic stream_overlap(input string tag);
    send({tag, " b1"}, 1'b1, 1'b0, 16'd0);
    send({tag, " b2"}, 1'b0, 1'b0, 16'd0);
    send({tag, " b3"}, 1'b1, 1'b0, 16'd0);
    send({tag, " b4"}, 1'b1, 1'b1, 16'd1);
    send({tag, " b5"}, 1'b0, 1'b0, 16'd1);
    send({tag, " b6"}, 1'b1, 1'b0, 16'd1);
    send({tag, " b7"}, 1'b1, 1'b1, 16'd2);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] p8;
    rst = 1'b1; start = 1'b0; abort = 1'b0; d_in = 1'b0; valid_in = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_target = '0;
    tick(); tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    tick();

    // 1: overlap
    do_start(8'h0B, 4'd4, 1'b1, 16'd5);
    check_outs("s1 start", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    stream_overlap("s1");
    check("s1 busy", busy, 1'b1);
    check("s1 done", done, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    check_outs("s1 abort", 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);

    // 2: non-overlap
    do_start(8'h0B, 4'd4, 1'b0, 16'd5);
    send("s2 b1", 1'b1, 1'b0, 16'd0);
    send("s2 b2", 1'b0, 1'b0, 16'd0);
    send("s2 b3", 1'b1, 1'b0, 16'd0);
    send("s2 b4", 1'b1, 1'b1, 16'd1);
    send("s2 b5", 1'b0, 1'b0, 16'd1);
    send("s2 b6", 1'b1, 1'b0, 16'd1);
    send("s2 b7", 1'b1, 1'b0, 16'd1);
    check("s2 busy", busy, 1'b1);
    abort = 1'b1; tick(); abort = 1'b0;

    // 3: target with a 2-cycle gap
    do_start(8'h03, 4'd2, 1'b1, 16'd3);
    send("s3 b1", 1'b1, 1'b0, 16'd0);
    send("s3 b2", 1'b1, 1'b1, 16'd1);
    d_in = 1'b0; tick(); tick();
    check("s3 gap det", pattern_detected, 1'b0);
    send("s3 b3", 1'b1, 1'b1, 16'd2);
    check("s3 b3 done", done, 1'b0);
    send("s3 b4", 1'b1, 1'b1, 16'd3);
    check("s3 b4 done", done, 1'b1);
    check("s3 b4 busy", busy, 1'b0);
    tick();
    check_outs("s3 idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);

    // 4: config errors
    do_start(8'h03, 4'd0, 1'b1, 16'd3);
    check_outs("s4 len0", 1'b0, 1'b0, 1'b0, 1'b1, 16'd3);
    tick();
    check("s4 err pulse", cfg_err, 1'b0);
    do_start(8'h03, 4'd9, 1'b1, 16'd3);
    check_outs("s4 len9", 1'b0, 1'b0, 1'b0, 1'b1, 16'd3);
    do_start(8'h03, 4'd2, 1'b1, 16'd0);
    check_outs("s4 tgt0", 1'b0, 1'b0, 1'b0, 1'b1, 16'd3);
    tick();
    check("s4 err clr", cfg_err, 1'b0);

    // 5: start gating and abort beating a completing match (target 2)
    do_start(8'h0B, 4'd4, 1'b1, 16'd2);
    send("s5 b1", 1'b1, 1'b0, 16'd0);
    send("s5 b2", 1'b0, 1'b0, 16'd0);
    send("s5 b3", 1'b1, 1'b0, 16'd0);
    send("s5 b4", 1'b1, 1'b1, 16'd1);
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_target = 16'd1; start = 1'b1;
    send("s5 b5", 1'b0, 1'b0, 16'd1);
    check("s5 gated err", cfg_err, 1'b0);
    check("s5 gated busy", busy, 1'b1);
    cfg_len = 4'd1;
    send("s5 b6", 1'b1, 1'b0, 16'd1);
    start = 1'b0;
    abort = 1'b1;
    send("s5 b7 abort", 1'b1, 1'b0, 16'd1);
    abort = 1'b0;
    check("s5 busy", busy, 1'b0);
    check("s5 done", done, 1'b0);
    tick();
    check_outs("s5 idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);

    // 6: reset mid-run, then a clean run
    do_start(8'h0B, 4'd4, 1'b1, 16'd5);
    send("s6 b1", 1'b1, 1'b0, 16'd0);
    send("s6 b2", 1'b0, 1'b0, 16'd0);
    send("s6 b3", 1'b1, 1'b0, 16'd0);
    send("s6 b4", 1'b1, 1'b1, 16'd1);
    rst = 1'b1; d_in = 1'b1; valid_in = 1'b1;
    tick();
    rst = 1'b0; valid_in = 1'b0;
    check_outs("s6 rst", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    do_start(8'h0B, 4'd4, 1'b1, 16'd5);
    stream_overlap("s6r");
    abort = 1'b1; tick(); abort = 1'b0;

    // Length boundaries: len=8 and len=1
    p8 = 8'hA5;
    do_start(p8, 4'd8, 1'b0, 16'd1);
    for (int i = 7; i >= 1; i--) send("s7 len8", p8[i], 1'b0, 16'd0);
    send("s7 len8 last", p8[0], 1'b1, 16'd1);
    check("s7 done", done, 1'b1);
    tick();
    do_start(8'h01, 4'd1, 1'b0, 16'd3);
    send("s8 b1", 1'b1, 1'b1, 16'd1);
    send("s8 b2", 1'b0, 1'b0, 16'd1);
    send("s8 b3", 1'b1, 1'b1, 16'd2);
    send("s8 b4", 1'b1, 1'b1, 16'd3);
    check("s8 done", done, 1'b1);
    check("s8 busy", busy, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
